// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control: multi-cycle MIPS sequencer with illegal-opcode and memory-timeout traps.
// Define MIPS_CTRL_PERF_EN to add saturating cycle_count / retired_count outputs.
module mips_multicycle_control #(
  parameter int MEM_TIMEOUT = 16,
  parameter int PERF_WIDTH  = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instruction,
  input  logic        alu_zero,
  input  logic        mem_ready,
  output logic        mem_request,
  output logic        mem_write_enable,
  output logic        mem_addr_source,
  output logic        ir_write_enable,
  output logic        pc_write_enable,
  output logic        pc_source,
  output logic        register_write_enable,
  output logic        register_write_data_source,
  output logic        register_write_address_source,
  output logic        alu_b_source,
  output logic [2:0]  alu_ctrl,
  output logic [2:0]  state,
`ifdef MIPS_CTRL_PERF_EN
  output logic [PERF_WIDTH-1:0] cycle_count,
  output logic [PERF_WIDTH-1:0] retired_count,
`endif
  output logic        illegal_instruction,
  output logic        bus_error
);
  typedef enum logic [2:0] {
    S_RESET      = 3'd0,
    S_FETCH      = 3'd1,
    S_DECODE     = 3'd2,
    S_EXECUTE    = 3'd3,
    S_MEM_ACCESS = 3'd4,
    S_WRITEBACK  = 3'd5,
    S_TRAP       = 3'd6
  } state_t;
  localparam int TW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  if (PERF_WIDTH < 1 || MEM_TIMEOUT < 0) begin : g_bad_cfg
    $error("mips_multicycle_control: invalid parameters");
  end
  state_t        state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          illegal_q, illegal_d, bus_error_q, bus_error_d;
  logic [5:0]    opcode, funct;
  logic          is_r, is_lw, is_sw, is_addi, is_andi, is_beq, legal;
  logic [2:0]    r_alu, alu_op;
  logic          in_fetch, in_exec, in_mem, in_wb, waiting, timeout_hit, expire;
  logic          unused_bits;
  assign opcode      = instruction[31:26];
  assign funct       = instruction[5:0];
  assign unused_bits = ^instruction[25:6];
  assign is_r    = opcode == 6'b000000 && (funct == 6'b100000 || funct == 6'b100100 ||
                                           funct == 6'b100101 || funct == 6'b100010);
  assign is_lw   = opcode == 6'b100011;
  assign is_sw   = opcode == 6'b101011;
  assign is_addi = opcode == 6'b001000;
  assign is_andi = opcode == 6'b001100;
  assign is_beq  = opcode == 6'b000100;
  assign legal   = is_r | is_lw | is_sw | is_addi | is_andi | is_beq;
  assign r_alu   = funct == 6'b100100 ? 3'b000 : funct == 6'b100101 ? 3'b001 :
                   funct == 6'b100010 ? 3'b110 : 3'b010;
  assign alu_op  = is_r ? r_alu : is_andi ? 3'b000 : is_beq ? 3'b110 : 3'b010;
  assign in_fetch = state_q == S_FETCH;
  assign in_exec  = state_q == S_EXECUTE;
  assign in_mem   = state_q == S_MEM_ACCESS;
  assign in_wb    = state_q == S_WRITEBACK;
  assign waiting  = in_fetch | in_mem;
  // A ready on the limit cycle completes the access rather than trapping.
  assign timeout_hit = (MEM_TIMEOUT > 0) && (tmo_q == TW'(MEM_TIMEOUT - 1));
  assign expire      = waiting && !mem_ready && timeout_hit;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_RESET;
      tmo_q       <= '0;
      illegal_q   <= 1'b0;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmo_q       <= tmo_d;
      illegal_q   <= illegal_d;
      bus_error_q <= bus_error_d;
    end
  end
  always_comb begin
    state_d     = state_q;
    tmo_d       = (waiting && !mem_ready) ? tmo_q + 1'b1 : '0;
    illegal_d   = illegal_q | (state_q == S_DECODE && !legal);
    bus_error_d = bus_error_q | expire;
    case (state_q)
      S_RESET:      state_d = S_FETCH;
      S_FETCH:      state_d = mem_ready ? S_DECODE : expire ? S_TRAP : S_FETCH;
      S_DECODE:     state_d = legal ? S_EXECUTE : S_TRAP;
      S_EXECUTE:    state_d = is_beq ? S_FETCH : (is_lw | is_sw) ? S_MEM_ACCESS : S_WRITEBACK;
      S_MEM_ACCESS: state_d = mem_ready ? (is_lw ? S_WRITEBACK : S_FETCH) :
                              expire ? S_TRAP : S_MEM_ACCESS;
      S_WRITEBACK:  state_d = S_FETCH;
      default:      state_d = (state_q == S_TRAP) ? S_TRAP : S_RESET;
    endcase
  end
  always_comb begin
    mem_request                   = waiting;
    mem_write_enable              = in_mem & is_sw;
    mem_addr_source               = in_mem;
    ir_write_enable               = in_fetch & mem_ready;
    pc_write_enable               = (in_fetch & mem_ready) | (in_exec & is_beq & alu_zero);
    pc_source                     = in_exec & is_beq;
    register_write_enable         = in_wb;
    register_write_data_source    = in_wb & is_lw;
    register_write_address_source = in_wb & is_r;
    alu_b_source                  = (in_exec | in_wb) & (is_r | is_beq);
    alu_ctrl                      = in_mem ? 3'b010 : (in_exec | in_wb) ? alu_op : 3'b000;
    state                         = state_q;
    illegal_instruction           = illegal_q;
    bus_error                     = bus_error_q;
  end
`ifdef MIPS_CTRL_PERF_EN
  logic [PERF_WIDTH-1:0] cyc_q, cyc_d, ret_q, ret_d;
  logic                  retire;
  always_comb begin
    retire = in_wb || (in_mem && is_sw && mem_ready) || (in_exec && is_beq);
    cyc_d  = (state_q != S_RESET && state_q != S_TRAP && !(&cyc_q)) ? cyc_q + 1'b1 : cyc_q;
    ret_d  = (retire && !(&ret_q)) ? ret_q + 1'b1 : ret_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q <= '0;
      ret_q <= '0;
    end else begin
      cyc_q <= cyc_d;
      ret_q <= ret_d;
    end
  end
  assign cycle_count   = cyc_q;
  assign retired_count = ret_q;
`endif
endmodule

// File: tb/tb_mips_multicycle_control.sv
// tb_mips_multicycle_control: directed vectors for the multi-cycle sequencer (MEM_TIMEOUT=4).
module tb_mips_multicycle_control;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] instruction = 32'h0;
  logic        alu_zero = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_request, mem_write_enable, mem_addr_source, ir_write_enable;
  logic        pc_write_enable, pc_source, register_write_enable;
  logic        register_write_data_source, register_write_address_source, alu_b_source;
  logic [2:0]  alu_ctrl, state;
  logic        illegal_instruction, bus_error;
`ifdef MIPS_CTRL_PERF_EN
  logic [31:0] cycle_count, retired_count;
`endif
  int tests = 0;
  int fails = 0;
  // {req,we,addr_src,ir_we,pc_we,pc_src,rf_we,rf_data_src,rf_addr_src,alu_b_src, alu_ctrl, state, illegal, bus_error}
  logic [17:0] obs;
  assign obs = {mem_request, mem_write_enable, mem_addr_source, ir_write_enable,
                pc_write_enable, pc_source, register_write_enable,
                register_write_data_source, register_write_address_source, alu_b_source,
                alu_ctrl, state, illegal_instruction, bus_error};
  localparam logic [17:0] S_RST   = 18'h0;
  localparam logic [17:0] S_FREQ  = {10'b1000000000, 3'b000, 3'd1, 2'b00};
  localparam logic [17:0] S_FDONE = {10'b1001100000, 3'b000, 3'd1, 2'b00};
  localparam logic [17:0] S_DEC   = {10'b0000000000, 3'b000, 3'd2, 2'b00};
  localparam logic [17:0] S_EX010 = {10'b0000000000, 3'b010, 3'd3, 2'b00};
  mips_multicycle_control #(.MEM_TIMEOUT(4), .PERF_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .instruction(instruction), .alu_zero(alu_zero),
    .mem_ready(mem_ready), .mem_request(mem_request), .mem_write_enable(mem_write_enable),
    .mem_addr_source(mem_addr_source), .ir_write_enable(ir_write_enable),
    .pc_write_enable(pc_write_enable), .pc_source(pc_source),
    .register_write_enable(register_write_enable),
    .register_write_data_source(register_write_data_source),
    .register_write_address_source(register_write_address_source),
    .alu_b_source(alu_b_source), .alu_ctrl(alu_ctrl), .state(state),
`ifdef MIPS_CTRL_PERF_EN
    .cycle_count(cycle_count), .retired_count(retired_count),
`endif
    .illegal_instruction(illegal_instruction), .bus_error(bus_error)
  );
  always #5 clk = ~clk;
  task automatic reset_dut;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask
  task automatic test_reset;
    logic [17:0] ev [4];
    ev = '{S_RST, S_RST, S_RST, S_FREQ};
    for (int i = 0; i < 4; i++) begin
      if (i == 2) rst_n = 1'b1;
      #1;
      tests++;
      if (obs !== ev[i]) begin
        fails++;
        $display("FAIL reset[%0d] got %h expected %h", i, obs, ev[i]);
      end
      if (i != 1) @(posedge clk);
      #1;
    end
  endtask
  task automatic test_add;
    logic [17:0] ev [6];
    ev = '{S_RST, S_FDONE, S_DEC, {10'b0000000001, 3'b010, 3'd3, 2'b00},
           {10'b0000001011, 3'b010, 3'd5, 2'b00}, S_FDONE};
    instruction = 32'h00221820;
    reset_dut();
    for (int i = 0; i < 6; i++) begin
      mem_ready = 1'b1;
      #1;
      tests++;
      if (obs !== ev[i]) begin
        fails++;
        $display("FAIL add[%0d] got %h expected %h", i, obs, ev[i]);
      end
      @(posedge clk);
      #1;
    end
  endtask
  task automatic test_lw_wait;
    logic [17:0] ev [10];
    logic        rdy [10];
    ev  = '{S_RST, S_FDONE, S_DEC, S_EX010,
            {10'b1010000000, 3'b010, 3'd4, 2'b00}, {10'b1010000000, 3'b010, 3'd4, 2'b00},
            {10'b1010000000, 3'b010, 3'd4, 2'b00}, {10'b1010000000, 3'b010, 3'd4, 2'b00},
            {10'b0000001100, 3'b010, 3'd5, 2'b00}, S_FREQ};
    rdy = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    instruction = 32'h8C220004;
    reset_dut();
    for (int i = 0; i < 10; i++) begin
      mem_ready = rdy[i];
      #1;
      tests++;
      if (obs !== ev[i]) begin
        fails++;
        $display("FAIL lw[%0d] got %h expected %h", i, obs, ev[i]);
      end
      @(posedge clk);
      #1;
    end
  endtask
  task automatic test_sw;
    logic [17:0] ev [6];
    logic        rdy [6];
    ev  = '{S_RST, S_FDONE, S_DEC, S_EX010, {10'b1110000000, 3'b010, 3'd4, 2'b00}, S_FREQ};
    rdy = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    instruction = 32'hAC220008;
    reset_dut();
    for (int i = 0; i < 6; i++) begin
      mem_ready = rdy[i];
      #1;
      tests++;
      if (obs !== ev[i]) begin
        fails++;
        $display("FAIL sw[%0d] got %h expected %h", i, obs, ev[i]);
      end
      @(posedge clk);
      #1;
    end
  endtask
  task automatic test_beq;
    logic [17:0] ev [8];
    logic        rdy [8];
    logic        zr [8];
    ev  = '{S_RST, S_FDONE, S_DEC, {10'b0000110001, 3'b110, 3'd3, 2'b00},
            S_FDONE, S_DEC, {10'b0000010001, 3'b110, 3'd3, 2'b00}, S_FREQ};
    rdy = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    zr  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    instruction = 32'h10220003;
    reset_dut();
    for (int i = 0; i < 8; i++) begin
      mem_ready = rdy[i];
      alu_zero  = zr[i];
      #1;
      tests++;
      if (obs !== ev[i]) begin
        fails++;
        $display("FAIL beq[%0d] got %h expected %h", i, obs, ev[i]);
      end
      @(posedge clk);
      #1;
    end
    alu_zero = 1'b0;
  endtask
  task automatic test_alu_ops;
    logic [31:0] ins [5];
    logic [17:0] ex [5];
    logic [17:0] wb [5];
    ins = '{32'h00221824, 32'h00221825, 32'h00221822, 32'h20220005, 32'h3022000F};
    ex  = '{{10'b0000000001, 3'b000, 3'd3, 2'b00}, {10'b0000000001, 3'b001, 3'd3, 2'b00},
            {10'b0000000001, 3'b110, 3'd3, 2'b00}, {10'b0000000000, 3'b010, 3'd3, 2'b00},
            {10'b0000000000, 3'b000, 3'd3, 2'b00}};
    wb  = '{{10'b0000001011, 3'b000, 3'd5, 2'b00}, {10'b0000001011, 3'b001, 3'd5, 2'b00},
            {10'b0000001011, 3'b110, 3'd5, 2'b00}, {10'b0000001000, 3'b010, 3'd5, 2'b00},
            {10'b0000001000, 3'b000, 3'd5, 2'b00}};
    for (int k = 0; k < 5; k++) begin
      instruction = ins[k];
      mem_ready = 1'b1;
      reset_dut();
      repeat (3) @(posedge clk);
      #1;
      tests++;
      if (obs !== ex[k]) begin
        fails++;
        $display("FAIL alu_exec[%0d] got %h expected %h", k, obs, ex[k]);
      end
      @(posedge clk);
      #1;
      tests++;
      if (obs !== wb[k]) begin
        fails++;
        $display("FAIL alu_wb[%0d] got %h expected %h", k, obs, wb[k]);
      end
    end
  endtask
  task automatic test_illegal;
    logic [31:0] ins [2];
    logic [17:0] trap_ill;
    ins = '{32'hFC000000, 32'h00221821};
    trap_ill = {10'b0000000000, 3'b000, 3'd6, 2'b10};
    for (int k = 0; k < 2; k++) begin
      instruction = ins[k];
      mem_ready = 1'b1;
      reset_dut();
      repeat (3) @(posedge clk);
      #1;
      tests++;
      if (obs !== trap_ill) begin
        fails++;
        $display("FAIL illegal_trap[%0d] got %h expected %h", k, obs, trap_ill);
      end
      @(posedge clk);
      #1;
      mem_ready = 1'b0;
      #1;
      tests++;
      if (obs !== trap_ill) begin
        fails++;
        $display("FAIL illegal_hold[%0d] got %h expected %h", k, obs, trap_ill);
      end
      rst_n = 1'b0;
      #1;
      tests++;
      if (obs !== S_RST) begin
        fails++;
        $display("FAIL illegal_reset[%0d] got %h expected %h", k, obs, S_RST);
      end
      rst_n = 1'b1;
      @(posedge clk);
      #1;
    end
  endtask
  task automatic test_timeout;
    logic [17:0] ev [7];
    logic [17:0] trap_be;
    trap_be = {10'b0000000000, 3'b000, 3'd6, 2'b01};
    ev = '{S_RST, S_FREQ, S_FREQ, S_FREQ, S_FREQ, trap_be, trap_be};
    instruction = 32'h00221820;
    mem_ready = 1'b0;
    reset_dut();
    for (int i = 0; i < 7; i++) begin
      #1;
      tests++;
      if (obs !== ev[i]) begin
        fails++;
        $display("FAIL timeout[%0d] got %h expected %h", i, obs, ev[i]);
      end
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if (obs !== S_RST) begin
      fails++;
      $display("FAIL timeout_trap_reset got %h expected %h", obs, S_RST);
    end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    tests++;
    if (obs !== S_RST) begin
      fails++;
      $display("FAIL midwait_reset got %h expected %h", obs, S_RST);
    end
    @(posedge clk);
    #1;
    tests++;
    if (obs !== S_RST) begin
      fails++;
      $display("FAIL midwait_reset_hold got %h expected %h", obs, S_RST);
    end
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    tests++;
    if (obs !== S_FREQ) begin
      fails++;
      $display("FAIL timeout_rearm got %h expected %h", obs, S_FREQ);
    end
  endtask
`ifdef MIPS_CTRL_PERF_EN
  task automatic test_perf;
    logic rdy [10];
    rdy = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    reset_dut();
    for (int i = 0; i < 10; i++) begin
      instruction = (i < 5) ? 32'hAC220008 : 32'h20220005;
      mem_ready = rdy[i];
      #1;
      if (i == 0) begin
        tests++;
        if (cycle_count !== 32'd0 || retired_count !== 32'd0) begin
          fails++;
          $display("FAIL perf_reset got %0d/%0d expected 0/0", cycle_count, retired_count);
        end
      end
      if (i < 9) @(posedge clk);
      #1;
    end
    tests++;
    if (retired_count !== 32'd2) begin
      fails++;
      $display("FAIL perf_retired got %0d expected 2", retired_count);
    end
    tests++;
    if (cycle_count !== 32'd8) begin
      fails++;
      $display("FAIL perf_cycles got %0d expected 8", cycle_count);
    end
  endtask
`endif
  initial begin
    #2;
    test_reset();
    test_add();
    test_lw_wait();
    test_sw();
    test_beq();
    test_alu_ops();
    test_illegal();
    test_timeout();
`ifdef MIPS_CTRL_PERF_EN
    test_perf();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
Multi-cycle sequencer for the MIPS datapath. Replaces single-cycle decode with a FSM that drives fetch, decode, execute, memory and writeback over multiple cycles, sharing one ALU and one ready-handshaked memory port between instruction fetch and data access. Sits between the instruction register / ALU-zero flag and the datapath enables. Traps illegal instructions and memory timeouts.

Parameters:
MEM_TIMEOUT, 16, max cycles waiting on mem_ready before bus error; 0 disables timeout
PERF_WIDTH, 32, width of performance counters (only with optional feature)

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
instruction  input  32  current instruction register contents
alu_zero  input  1  ALU result == 0
mem_ready  input  1  memory completes current request this cycle
mem_request  output  1  memory access requested; held until mem_ready
mem_write_enable  output  1  request is a write (sw)
mem_addr_source  output  1  0 = PC, 1 = ALU result
ir_write_enable  output  1  load instruction register from memory read data
pc_write_enable  output  1  update PC
pc_source  output  1  0 = PC+4 (datapath incrementer), 1 = branch target
register_write_enable  output  1  register file write strobe
register_write_data_source  output  1  0 = ALU result, 1 = memory data
register_write_address_source  output  1  0 = instruction[20:16], 1 = instruction[15:11]
alu_b_source  output  1  0 = sign-extended immediate, 1 = register
alu_ctrl  output  3  000 and, 001 or, 010 add, 110 sub
state  output  3  current state encoding
illegal_instruction  output  1  sticky; undecodable instruction trapped
bus_error  output  1  sticky; memory timeout trapped

Behaviour:
- States/encoding: RESET=0, FETCH=1, DECODE=2, EXECUTE=3, MEM_ACCESS=4, WRITEBACK=5, TRAP=6. Registered state; outputs combinational from state + instruction.
- Reset (async, any time, mid-access included): state=RESET, illegal_instruction=0, bus_error=0, timeout counter=0. In RESET every output 0. RESET -> FETCH on first clk edge after rst_n high.
- FETCH: mem_request=1, mem_addr_source=0. Stay until mem_ready; on that cycle ir_write_enable=1, pc_write_enable=1, pc_source=0; -> DECODE.
- DECODE: one cycle, no strobes. Legal: opcode 000000 with funct 100000/100100/100101/100010 (add/and/or/sub), 100011 lw, 101011 sw, 001000 addi, 001100 andi, 000100 beq. Legal -> EXECUTE; otherwise -> TRAP, set illegal_instruction.
- EXECUTE: alu_ctrl = funct mapping for R-format, 010 for lw/sw/addi, 000 andi, 110 beq; alu_b_source=1 for R-format and beq. beq: pc_write_enable=alu_zero, pc_source=1, -> FETCH. lw/sw -> MEM_ACCESS. R/addi/andi -> WRITEBACK.
- MEM_ACCESS: mem_request=1, mem_addr_source=1, mem_write_enable=1 for sw; alu_ctrl=010 held. Stay until mem_ready; lw -> WRITEBACK, sw -> FETCH.
- WRITEBACK: register_write_enable=1 exactly one cycle; register_write_data_source=1 for lw; register_write_address_source=1 for R-format; alu controls held as EXECUTE. -> FETCH.
- mem_ready ignored when mem_request=0.
- Timeout: counter clears on entry to FETCH/MEM_ACCESS, increments each waiting cycle without mem_ready. If MEM_TIMEOUT>0 and counter reaches MEM_TIMEOUT with mem_ready still low -> TRAP, set bus_error, deassert mem_request. mem_ready on the same edge as the limit wins (access completes).
- TRAP: all strobes 0; exits only via reset.

Optional Feature:
MIPS_CTRL_PERF_EN: adds outputs cycle_count and retired_count (PERF_WIDTH each), reset 0. cycle_count increments every cycle outside RESET/TRAP; retired_count increments on WRITEBACK, sw MEM_ACCESS completion, and beq EXECUTE. Both saturate at all-ones. Without macro: ports and logic absent.

Test Plan:
- Reset release, add $3,$1,$2 (0x00221820), mem_ready immediate -> states 1,2,3,5,1; register_write_enable one cycle with address_source=1, alu_ctrl=010.
- lw with mem_ready delayed 3 cycles in MEM_ACCESS -> mem_request/mem_addr_source=1 held 4 cycles, then WRITEBACK with data_source=1.
- beq, alu_zero=1 then alu_zero=0 -> pc_write_enable=1/pc_source=1 in EXECUTE only when zero; both return to FETCH.
- Opcode 111111 -> TRAP after DECODE, illegal_instruction=1, no strobes until rst_n low.
- MEM_TIMEOUT=4, mem_ready never in FETCH -> TRAP after 4 wait cycles, bus_error=1; rst_n low mid-wait -> state=0 immediately, flags clear.
- With MIPS_CTRL_PERF_EN, run sw then addi -> retired_count=2.
